// File: rtl/reg_bank_dump.sv
// rtl/reg_bank_dump.sv - MIPS register file with combinational reads, bypass and debug dump engine
// Dump engine streams every implemented register over a valid/ready handshake without stalling the pipeline.
module reg_bank_dump #(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 5,
   parameter int NUM_REGS     = 32,
   parameter int ZERO_REG     = 1,
   parameter int WRITE_BYPASS = 1
) (
   input  logic                  i_clock,
   input  logic                  i_reset,
   input  logic                  i_regwrite,
   input  logic [ADDR_WIDTH-1:0] i_wr_addr,
   input  logic [DATA_WIDTH-1:0] i_wr_data,
   input  logic [ADDR_WIDTH-1:0] i_rs,
   input  logic [ADDR_WIDTH-1:0] i_rt,
   output logic [DATA_WIDTH-1:0] o_regA,
   output logic [DATA_WIDTH-1:0] o_regB,
   input  logic                  i_dump_start,
   input  logic                  i_dump_ready,
   output logic                  o_dump_valid,
   output logic [ADDR_WIDTH-1:0] o_dump_addr,
   output logic [DATA_WIDTH-1:0] o_dump_data,
   output logic                  o_dump_busy,
   output logic                  o_dump_done
);

   localparam logic [ADDR_WIDTH:0]   LIMIT = (ADDR_WIDTH+1)'(NUM_REGS);
   localparam logic [ADDR_WIDTH-1:0] LAST  = ADDR_WIDTH'(NUM_REGS - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      DONE = 2'd2
   } state_t;

   logic [DATA_WIDTH-1:0] mem [NUM_REGS];
   state_t                state;
   state_t                next_state;
   logic [ADDR_WIDTH-1:0] index;
   logic [ADDR_WIDTH-1:0] next_index;

   function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr);
      return {1'b0, addr} < LIMIT;
   endfunction

   function automatic logic is_zero_reg(input logic [ADDR_WIDTH-1:0] addr);
      return (ZERO_REG != 0) && (addr == '0);
   endfunction

   function automatic logic writable(input logic [ADDR_WIDTH-1:0] addr);
      return in_range(addr) && !is_zero_reg(addr);
   endfunction

   // Shared by both read ports and the dump path so all three see identical zero/bypass rules.
   function automatic logic [DATA_WIDTH-1:0] read_port(input logic [ADDR_WIDTH-1:0] addr);
      logic [DATA_WIDTH-1:0] value;
      value = '0;
      if (in_range(addr) && !is_zero_reg(addr)) begin
         if ((WRITE_BYPASS != 0) && i_regwrite && (addr == i_wr_addr) && writable(i_wr_addr))
            value = i_wr_data;
         else
            value = mem[addr];
      end
      return value;
   endfunction

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         for (int i = 0; i < NUM_REGS; i++)
            mem[i] <= '0;
      end else if (i_regwrite && writable(i_wr_addr)) begin
         mem[i_wr_addr] <= i_wr_data;
      end
   end

   assign o_regA = read_port(i_rs);
   assign o_regB = read_port(i_rt);

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         state <= IDLE;
         index <= '0;
      end else begin
         state <= next_state;
         index <= next_index;
      end
   end

   always_comb begin
      next_state   = state;
      next_index   = index;
      o_dump_valid = 1'b0;
      o_dump_busy  = 1'b0;
      o_dump_done  = 1'b0;
      case (state)
         IDLE: begin
            if (i_dump_start) begin
               next_state = SEND;
               next_index = '0;
            end
         end
         SEND: begin
            o_dump_valid = 1'b1;
            o_dump_busy  = 1'b1;
            if (i_dump_ready) begin
               if (index == LAST) begin
                  next_state = DONE;
                  next_index = '0;
               end else begin
                  next_index = index + 1'b1;
               end
            end
         end
         DONE: begin
            o_dump_busy = 1'b1;
            o_dump_done = 1'b1;
            next_state  = IDLE;
            next_index  = '0;
         end
         default: begin
            next_state = IDLE;
            next_index = '0;
         end
      endcase
   end

   // Data follows live contents while stalled, so a write during a stall is what gets accepted.
   assign o_dump_addr = index;
   assign o_dump_data = o_dump_valid ? read_port(index) : '0;

endmodule

// File: tb/tb_reg_bank_dump.sv
// tb/tb_reg_bank_dump.sv - self-checking bench for reg_bank_dump across three parameter sets
// Instances: u0 default, u1 without bypass, u2 with 24 registers and an ordinary r0.
module tb_reg_bank_dump;

   logic        clk = 1'b0;
   logic        rst;
   logic        regwrite;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic        dump_start;
   logic        dump_ready;

   logic [31:0] ra [3];
   logic [31:0] rb [3];
   logic        dv [3];
   logic [4:0]  da [3];
   logic [31:0] dd [3];
   logic        bsy [3];
   logic        dn [3];

   int checks = 0;
   int errors = 0;

   logic [31:0] mm [3][32];
   int ph [3];
   int ix [3];

   int busy_cnt0, acc_cnt0, done_cnt0, done_cnt2;
   logic [31:0] word4;

   always #5 clk = ~clk;

   reg_bank_dump #(.NUM_REGS(32), .ZERO_REG(1), .WRITE_BYPASS(1)) u0 (
      .i_clock(clk), .i_reset(rst), .i_regwrite(regwrite), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
      .i_rs(rs), .i_rt(rt), .o_regA(ra[0]), .o_regB(rb[0]), .i_dump_start(dump_start),
      .i_dump_ready(dump_ready), .o_dump_valid(dv[0]), .o_dump_addr(da[0]), .o_dump_data(dd[0]),
      .o_dump_busy(bsy[0]), .o_dump_done(dn[0]));

   reg_bank_dump #(.NUM_REGS(32), .ZERO_REG(1), .WRITE_BYPASS(0)) u1 (
      .i_clock(clk), .i_reset(rst), .i_regwrite(regwrite), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
      .i_rs(rs), .i_rt(rt), .o_regA(ra[1]), .o_regB(rb[1]), .i_dump_start(dump_start),
      .i_dump_ready(dump_ready), .o_dump_valid(dv[1]), .o_dump_addr(da[1]), .o_dump_data(dd[1]),
      .o_dump_busy(bsy[1]), .o_dump_done(dn[1]));

   reg_bank_dump #(.NUM_REGS(24), .ZERO_REG(0), .WRITE_BYPASS(1)) u2 (
      .i_clock(clk), .i_reset(rst), .i_regwrite(regwrite), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
      .i_rs(rs), .i_rt(rt), .o_regA(ra[2]), .o_regB(rb[2]), .i_dump_start(dump_start),
      .i_dump_ready(dump_ready), .o_dump_valid(dv[2]), .o_dump_addr(da[2]), .o_dump_data(dd[2]),
      .o_dump_busy(bsy[2]), .o_dump_done(dn[2]));

   function automatic int nr(input int k);
      return (k == 2) ? 24 : 32;
   endfunction

   function automatic bit zr(input int k);
      return k != 2;
   endfunction

   function automatic bit bp(input int k);
      return k != 1;
   endfunction

   function automatic bit wable(input int k, input logic [4:0] a);
      return (int'(a) < nr(k)) && !(zr(k) && a == 5'd0);
   endfunction

   // What a read of address a should return this cycle, from the register-file rules.
   function automatic logic [31:0] mread(input int k, input logic [4:0] a);
      if (int'(a) >= nr(k)) return 32'd0;
      if (zr(k) && a == 5'd0) return 32'd0;
      if (bp(k) && regwrite && a == wr_addr && wable(k, wr_addr)) return wr_data;
      return mm[k][a];
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 3; k++) begin
         for (int r = 0; r < 32; r++) mm[k][r] = 32'd0;
         ph[k] = 0;
         ix[k] = 0;
      end
   endtask

   task automatic model_step();
      for (int k = 0; k < 3; k++) begin
         if (ph[k] == 0) begin
            if (dump_start) begin ph[k] = 1; ix[k] = 0; end
         end else if (ph[k] == 1) begin
            if (dump_ready) begin
               if (ix[k] == nr(k) - 1) begin ph[k] = 2; ix[k] = 0; end
               else ix[k] = ix[k] + 1;
            end
         end else begin
            ph[k] = 0;
         end
         if (regwrite && wable(k, wr_addr)) mm[k][wr_addr] = wr_data;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("regA[%0d] rs=%0d", k, rs), ra[k], mread(k, rs));
         chk($sformatf("regB[%0d] rt=%0d", k, rt), rb[k], mread(k, rt));
         chk($sformatf("valid[%0d]", k), 32'(dv[k]), 32'(ph[k] == 1));
         chk($sformatf("busy[%0d]", k), 32'(bsy[k]), 32'(ph[k] != 0));
         chk($sformatf("done[%0d]", k), 32'(dn[k]), 32'(ph[k] == 2));
         chk($sformatf("daddr[%0d]", k), 32'(da[k]), 32'(ix[k]));
         chk($sformatf("ddata[%0d] idx=%0d", k, ix[k]), dd[k],
             (ph[k] == 1) ? mread(k, 5'(ix[k])) : 32'd0);
      end
      if (bsy[0]) busy_cnt0++;
      if (dv[0] && dump_ready) begin
         acc_cnt0++;
         if (da[0] == 5'd4) word4 = dd[0];
      end
      if (dn[0]) done_cnt0++;
      if (dn[2]) done_cnt2++;
   endtask

   task automatic clear_counts();
      busy_cnt0 = 0; acc_cnt0 = 0; done_cnt0 = 0; done_cnt2 = 0; word4 = 32'd0;
   endtask

   task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic [4:0] a, input logic [4:0] b, input logic st, input logic rd);
      @(negedge clk);
      regwrite = we; wr_addr = wa; wr_data = wd; rs = a; rt = b;
      dump_start = st; dump_ready = rd;
      #1;
      check_all();
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      model_step();
   endtask

   // Reset raised mid-cycle: outputs must clear before any clock edge.
   task automatic do_reset();
      @(negedge clk);
      regwrite = 1'b0; dump_start = 1'b0;
      #2 rst = 1'b1;
      #1;
      model_reset();
      check_all();
      @(posedge clk);
      #1;
      check_all();
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      int n;
      logic [4:0] a5;
      rst = 1'b1; regwrite = 1'b0; wr_addr = '0; wr_data = '0; rs = '0; rt = '0;
      dump_start = 1'b0; dump_ready = 1'b0;
      model_reset();
      clear_counts();
      @(negedge clk);
      #1 check_all();
      rst = 1'b0;

      // Write r5 then reset asynchronously.
      drive(1'b1, 5'd5, 32'hDEAD, 5'd5, 5'd5, 1'b0, 1'b0); tick();
      drive(1'b0, 5'd0, 32'd0, 5'd5, 5'd5, 1'b0, 1'b0);
      chk("r5 written", ra[0], 32'hDEAD);
      do_reset();
      drive(1'b0, 5'd0, 32'd0, 5'd5, 5'd5, 1'b0, 1'b0);
      chk("r5 after reset", ra[0], 32'd0);
      chk("valid after reset", 32'(dv[0]), 32'd0);

      // r7 and r0 writes.
      drive(1'b1, 5'd7, 32'h12345678, 5'd0, 5'd0, 1'b0, 1'b0); tick();
      drive(1'b1, 5'd0, 32'hFFFF, 5'd7, 5'd1, 1'b0, 1'b0); tick();
      chk("r7 read", ra[0], 32'h12345678);
      drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd7, 1'b0, 1'b0);
      chk("r0 zero", ra[0], 32'd0);
      chk("r0 ordinary", ra[2], 32'hFFFF);

      // Same-cycle bypass on both ports versus no bypass.
      drive(1'b1, 5'd9, 32'h11111111, 5'd0, 5'd0, 1'b0, 1'b0); tick();
      drive(1'b1, 5'd9, 32'hA5A5A5A5, 5'd9, 5'd9, 1'b0, 1'b0);
      chk("bypass A", ra[0], 32'hA5A5A5A5);
      chk("bypass B", rb[0], 32'hA5A5A5A5);
      chk("no bypass A", ra[1], 32'h11111111);
      chk("no bypass B", rb[1], 32'h11111111);
      tick();

      // Load rN = N*3 and dump with ready held high.
      for (int r = 0; r < 32; r++) begin
         drive(1'b1, 5'(r), 32'(r * 3), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 1'b0, 1'b1);
         tick();
      end
      clear_counts();
      drive(1'b0, 5'd0, 32'd0, 5'd3, 5'd4, 1'b1, 1'b1); tick();
      n = 0;
      while ((ph[0] != 0 || ph[2] != 0) && n < 60) begin
         drive(1'b0, 5'd0, 32'd0, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 1'b0, 1'b1);
         tick();
         n++;
      end
      chk("dump1 bound", 32'(n < 60), 32'd1);
      chk("dump1 busy cycles", 32'(busy_cnt0), 32'd33);
      chk("dump1 words", 32'(acc_cnt0), 32'd32);
      chk("dump1 done pulses", 32'(done_cnt0), 32'd1);
      chk("dump1 word4", word4, 32'd12);

      // Dump with ready pattern 1,0,0,1 and a write to r4 while it stalls.
      clear_counts();
      drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b1, 1'b1); tick();
      n = 0;
      while ((ph[0] != 0 || ph[2] != 0) && n < 200) begin
         logic rdy;
         logic we;
         rdy = (n % 4 == 0) || (n % 4 == 3);
         we = 1'b0;
         if (ph[0] == 1 && ix[0] == 4 && word4 == 32'd0 && n < 150 && !regwrite) begin
            rdy = 1'b0;
            we = 1'b1;
         end
         drive(we, 5'd4, 32'hCAFEF00D, 5'd4, 5'($urandom_range(0, 31)), 1'b0, rdy);
         tick();
         n++;
      end
      chk("dump2 bound", 32'(n < 200), 32'd1);
      chk("dump2 words", 32'(acc_cnt0), 32'd32);
      chk("dump2 word4", word4, 32'hCAFEF00D);
      chk("dump2 done pulses", 32'(done_cnt0), 32'd1);

      // Out-of-range write on the 24-register instance.
      drive(1'b1, 5'd30, 32'h30303030, 5'd0, 5'd0, 1'b0, 1'b0); tick();
      drive(1'b0, 5'd0, 32'd0, 5'd30, 5'd30, 1'b0, 1'b0);
      chk("r30 ignored", ra[2], 32'd0);
      chk("r30 stored", ra[0], 32'h30303030);

      // Reset while the dump is at index 10.
      clear_counts();
      drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b1, 1'b1); tick();
      n = 0;
      while (ix[2] != 10 && n < 40) begin
         drive(1'b0, 5'd0, 32'd0, 5'd1, 5'd2, 1'b0, 1'b1); tick();
         n++;
      end
      chk("abort bound", 32'(n < 40), 32'd1);
      chk("abort at addr", 32'(da[2]), 32'd10);
      do_reset();
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 5'd0, 32'd0, 5'd1, 5'd2, 1'b0, 1'b1); tick();
      end
      chk("abort no done", 32'(done_cnt2 + done_cnt0), 32'd0);

      // Randomized traffic against the model.
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 149) == 0) begin
            do_reset();
         end else begin
            a5 = 5'($urandom_range(0, 31));
            drive(1'($urandom_range(0, 1)), a5, $urandom,
                  ($urandom_range(0, 3) == 0) ? a5 : 5'($urandom_range(0, 31)),
                  5'($urandom_range(0, 31)), ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)));
            tick();
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
